// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment counter family.
package seven_seg_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // Active-high glyphs, bit order A..G = [6]..[0], indexed by digit value.
    localparam logic [SEG_W-1:0] SEG_PAT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] seg,
                                                      input logic             active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seven_seg_counter_n_if.sv
// Control and display bundle between the switch logic and the counter.
interface seven_seg_counter_n_if
    import seven_seg_pkg::*;
#(
    parameter int unsigned N_DIGITS = 2
);
    logic                          i_en;
    logic                          i_up;
    logic                          i_clear;
    logic                          i_load;
    logic [DIGIT_W*N_DIGITS-1:0]   i_load_val;
    logic [DIGIT_W*N_DIGITS-1:0]   o_count;
    logic [SEG_W*N_DIGITS-1:0]     o_seg;
    logic                          o_tick;
    logic                          o_wrap;

    modport master (
        output i_en, i_up, i_clear, i_load, i_load_val,
        input  o_count, o_seg, o_tick, o_wrap
    );

    modport slave (
        input  i_en, i_up, i_clear, i_load, i_load_val,
        output o_count, o_seg, o_tick, o_wrap
    );
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational digit-to-glyph decoder (active-high segments).
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic               blank_i,
    output logic [SEG_W-1:0]   seg_o
);

    // Blanking overrides the glyph lookup.
    always_comb begin
        seg_o = blank_i ? SEG_BLANK : SEG_PAT[digit_i];
    end

endmodule

// File: rtl/seven_seg_counter_n.sv
// N-digit radix-10/16 up/down counter with prescaler and registered
// seven-segment outputs. Optional macro SEVEN_SEG_BLANK_LEADING_EN blanks
// leading zero digits (digit 0 is always shown).
module seven_seg_counter_n
    import seven_seg_pkg::*;
#(
    parameter int unsigned PERIOD         = 25000000,
    parameter int unsigned N_DIGITS       = 2,
    parameter int unsigned RADIX          = 10,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic                  i_Clk,
    input  logic                  rst,
    seven_seg_counter_n_if.slave  bus
);

    localparam int unsigned PW = $clog2(PERIOD);
    localparam int unsigned CW = DIGIT_W * N_DIGITS;
    localparam int unsigned SW = SEG_W * N_DIGITS;
    localparam logic [PW-1:0]      PRESC_MAX = PW'(PERIOD - 1);
    localparam logic [DIGIT_W-1:0] DIG_MAX   = DIGIT_W'(RADIX - 1);
    localparam logic               ACT_LOW   = (SEG_ACTIVE_LOW != 0);

    if (!(RADIX == 10 || RADIX == 16)) begin : g_bad_radix
        $error("seven_seg_counter_n: RADIX must be 10 or 16");
    end
    if (PERIOD < 2) begin : g_bad_period
        $error("seven_seg_counter_n: PERIOD must be at least 2");
    end
    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
        $error("seven_seg_counter_n: N_DIGITS must be 1..8");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] seg_q, seg_d, seg_raw;
    logic          wrap_q, wrap_d;
    logic [N_DIGITS-1:0] blank;
    logic          tick;
    logic          carry;
    logic [DIGIT_W-1:0] dig;

    assign tick = bus.i_en && (presc_q == PRESC_MAX);

    // Next prescaler, count and wrap; clear beats load beats tick step.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b0;
        dig     = '0;
        if (bus.i_en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (bus.i_clear) begin
            presc_d = '0;
            count_d = '0;
        end else if (bus.i_load) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                dig = bus.i_load_val[k*DIGIT_W +: DIGIT_W];
                count_d[k*DIGIT_W +: DIGIT_W] = (dig > DIG_MAX) ? DIG_MAX : dig;
            end
        end else if (tick) begin
            // Carry/borrow ripples while digits roll over; leftover means wrap.
            carry = 1'b1;
            for (int k = 0; k < N_DIGITS; k++) begin
                dig = count_q[k*DIGIT_W +: DIGIT_W];
                if (carry) begin
                    if (bus.i_up) begin
                        if (dig == DIG_MAX) begin
                            count_d[k*DIGIT_W +: DIGIT_W] = '0;
                        end else begin
                            count_d[k*DIGIT_W +: DIGIT_W] = dig + 1'b1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (dig == '0) begin
                            count_d[k*DIGIT_W +: DIGIT_W] = DIG_MAX;
                        end else begin
                            count_d[k*DIGIT_W +: DIGIT_W] = dig - 1'b1;
                            carry = 1'b0;
                        end
                    end
                end
            end
            wrap_d = carry;
        end
    end

`ifdef SEVEN_SEG_BLANK_LEADING_EN
    logic any_nz;

    // Blank digit k when it and every digit above it are zero; digit 0 stays lit.
    always_comb begin
        any_nz = 1'b0;
        blank  = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            any_nz   = any_nz | (count_q[k*DIGIT_W +: DIGIT_W] != '0);
            blank[k] = (k != 0) && !any_nz;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
        seven_seg_decode u_dec (
            .digit_i (count_q[k*DIGIT_W +: DIGIT_W]),
            .blank_i (blank[k]),
            .seg_o   (seg_raw[k*SEG_W +: SEG_W])
        );
    end

    // Apply output polarity to the decoded glyphs.
    always_comb begin
        seg_d = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            seg_d[k*SEG_W +: SEG_W] = seg_polarity(seg_raw[k*SEG_W +: SEG_W], ACT_LOW);
        end
    end

    // State registers; segment reset value matches what a zero count decodes to.
    always_ff @(posedge i_Clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            for (int k = 0; k < N_DIGITS; k++) begin
`ifdef SEVEN_SEG_BLANK_LEADING_EN
                seg_q[k*SEG_W +: SEG_W] <= seg_polarity((k == 0) ? SEG_PAT[0] : SEG_BLANK,
                                                        ACT_LOW);
`else
                seg_q[k*SEG_W +: SEG_W] <= seg_polarity(SEG_PAT[0], ACT_LOW);
`endif
            end
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.o_count = count_q;
    assign bus.o_seg   = seg_q;
    assign bus.o_wrap  = wrap_q;
    assign bus.o_tick  = tick && !bus.i_clear;

endmodule

// File: tb/tb_seven_seg_counter_n.sv
// Bench for seven_seg_counter_n: radix-10 and radix-16 instances share stimulus
// and are checked every cycle against a value-level model plus literal pins.
module tb_seven_seg_counter_n;

    localparam int unsigned P  = 4;
    localparam int unsigned ND = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, up = 1'b1, clr = 1'b0, ld = 1'b0;
    logic [7:0] lv = 8'h00;
    bit   chk_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seven_seg_counter_n_if #(.N_DIGITS(ND)) bus10 ();
    seven_seg_counter_n_if #(.N_DIGITS(ND)) bus16 ();

    assign bus10.i_en = en;  assign bus10.i_up = up;  assign bus10.i_clear = clr;
    assign bus10.i_load = ld; assign bus10.i_load_val = lv;
    assign bus16.i_en = en;  assign bus16.i_up = up;  assign bus16.i_clear = clr;
    assign bus16.i_load = ld; assign bus16.i_load_val = lv;

    seven_seg_counter_n #(.PERIOD(P), .N_DIGITS(ND), .RADIX(10), .SEG_ACTIVE_LOW(1)) dut10 (
        .i_Clk (clk),
        .rst   (rst),
        .bus   (bus10)
    );

    seven_seg_counter_n #(.PERIOD(P), .N_DIGITS(ND), .RADIX(16), .SEG_ACTIVE_LOW(1)) dut16 (
        .i_Clk (clk),
        .rst   (rst),
        .bus   (bus16)
    );

    // ---------------- model: count held as a plain integer ----------------
    int unsigned rad [2] = '{10, 16};
    int unsigned m_val [2];
    int unsigned m_segv [2];
    bit          m_wrap [2];
    int unsigned m_presc;

    function automatic int unsigned modulus(input int unsigned r);
        return r ** ND;
    endfunction

    function automatic int unsigned clamp_load(input logic [7:0] v, input int unsigned r);
        int unsigned acc = 0;
        int unsigned d;
        for (int k = ND - 1; k >= 0; k--) begin
            d = v[4*k +: 4];
            if (d >= r) d = r - 1;
            acc = acc * r + d;
        end
        return acc;
    endfunction

    function automatic logic [7:0] pack(input int unsigned v, input int unsigned r);
        logic [7:0] p = '0;
        for (int k = 0; k < ND; k++) p[4*k +: 4] = 4'((v / (r ** k)) % r);
        return p;
    endfunction

    function automatic logic [6:0] glyph(input int unsigned d);
        case (d)
            0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
            3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
            6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
            9: return 7'b1111011;  10: return 7'b1110111; 11: return 7'b0011111;
            12: return 7'b1001110; 13: return 7'b0111101; 14: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    function automatic logic [13:0] seg_of(input int unsigned v, input int unsigned r);
        logic [13:0] s = '0;
        logic [6:0]  g;
        for (int k = 0; k < ND; k++) begin
            g = glyph((v / (r ** k)) % r);
`ifdef SEVEN_SEG_BLANK_LEADING_EN
            if (k > 0 && (v / (r ** k)) == 0) g = 7'b0000000;
`endif
            s[7*k +: 7] = ~g;
        end
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_presc <= 0;
            for (int i = 0; i < 2; i++) begin
                m_val[i]  <= 0;
                m_segv[i] <= 0;
                m_wrap[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) m_segv[i] <= m_val[i];
            if (clr) begin
                m_presc <= 0;
                for (int i = 0; i < 2; i++) begin
                    m_val[i]  <= 0;
                    m_wrap[i] <= 1'b0;
                end
            end else begin
                if (en) m_presc <= (m_presc + 1) % P;
                for (int i = 0; i < 2; i++) begin
                    if (ld) begin
                        m_val[i]  <= clamp_load(lv, rad[i]);
                        m_wrap[i] <= 1'b0;
                    end else if (en && m_presc == P - 1) begin
                        if (up) begin
                            m_val[i]  <= (m_val[i] + 1) % modulus(rad[i]);
                            m_wrap[i] <= (m_val[i] == modulus(rad[i]) - 1);
                        end else begin
                            m_val[i]  <= (m_val[i] + modulus(rad[i]) - 1) % modulus(rad[i]);
                            m_wrap[i] <= (m_val[i] == 0);
                        end
                    end else begin
                        m_wrap[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_inst(input string tag, input int i, input logic [7:0] cnt,
                            input logic [13:0] seg, input logic tk, input logic wr);
        chk({tag, ".count"}, 32'(cnt), 32'(pack(m_val[i], rad[i])));
        chk({tag, ".seg"},   32'(seg), 32'(seg_of(m_segv[i], rad[i])));
        chk({tag, ".tick"},  32'(tk),  32'(en && m_presc == P - 1 && !clr));
        chk({tag, ".wrap"},  32'(wr),  32'(m_wrap[i]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst("r10", 0, bus10.o_count, bus10.o_seg, bus10.o_tick, bus10.o_wrap);
            cmp_inst("r16", 1, bus16.o_count, bus16.o_seg, bus16.o_tick, bus16.o_wrap);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (bus10.o_tick !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        if (n >= 20) begin
            n_vec++;
            n_err++;
            $display("FAIL tick_timeout: got no tick within %0d cycles, required one", n);
        end
    endtask

    logic [13:0] seg_rst;
    logic [6:0]  hi_zero;
    int          nt;

    initial begin
`ifdef SEVEN_SEG_BLANK_LEADING_EN
        seg_rst = {7'b1111111, 7'b0000001};
        hi_zero = 7'b1111111;
`else
        seg_rst = {7'b0000001, 7'b0000001};
        hi_zero = 7'b0000001;
`endif
        step(2);
        rst = 1'b0; en = 1'b1; up = 1'b1; chk_en = 1'b1;
        chk("reset_count", 32'(bus10.o_count), 32'h00);
        chk("reset_seg", 32'(bus10.o_seg), 32'(seg_rst));
        chk("reset_wrap", 32'(bus10.o_wrap), 32'h0);

        // Ten ticks of 4 cycles each.
        step(40);
        chk("up10_count", 32'(bus10.o_count), 32'h10);
        chk("up16_count", 32'(bus16.o_count), 32'h0A);

        // Overflow from 0x99.
        ld = 1'b1; lv = 8'h99; step(1); ld = 1'b0;
        chk("load99", 32'(bus10.o_count), 32'h99);
        wait_tick(nt); step(1);
        chk("wrap10_count", 32'(bus10.o_count), 32'h00);
        chk("wrap10_pulse", 32'(bus10.o_wrap), 32'h1);
        chk("r16_no_wrap", 32'(bus16.o_count), 32'h9A);
        step(1);
        chk("wrap10_one_cycle", 32'(bus10.o_wrap), 32'h0);

        // Overflow from 0xFF (clamped to 0x99 in radix 10).
        ld = 1'b1; lv = 8'hFF; step(1); ld = 1'b0;
        chk("loadFF_r10", 32'(bus10.o_count), 32'h99);
        chk("loadFF_r16", 32'(bus16.o_count), 32'hFF);
        wait_tick(nt); step(1);
        chk("wrap16_count", 32'(bus16.o_count), 32'h00);
        chk("wrap16_pulse", 32'(bus16.o_wrap), 32'h1);

        // Underflow, then direction flip mid-period.
        clr = 1'b1; step(1); clr = 1'b0;
        chk("clear", 32'(bus10.o_count), 32'h00);
        up = 1'b0;
        wait_tick(nt); step(1);
        chk("under10", 32'(bus10.o_count), 32'h99);
        chk("under16", 32'(bus16.o_count), 32'hFF);
        chk("under_wrap", 32'(bus10.o_wrap), 32'h1);
        step(1); up = 1'b1;
        wait_tick(nt); step(1);
        chk("flip_up10", 32'(bus10.o_count), 32'h00);

        // Load clamping, clear-vs-load priority, load coincident with tick.
        ld = 1'b1; lv = 8'hC7; step(1); ld = 1'b0;
        chk("clampC7_r10", 32'(bus10.o_count), 32'h97);
        chk("clampC7_r16", 32'(bus16.o_count), 32'hC7);
        clr = 1'b1; ld = 1'b1; step(1); clr = 1'b0; ld = 1'b0;
        chk("clear_over_load", 32'(bus10.o_count), 32'h00);
        wait_tick(nt);
        ld = 1'b1; lv = 8'h42; step(1); ld = 1'b0;
        chk("load_on_tick", 32'(bus10.o_count), 32'h42);
        step(1);
        chk("load_on_tick_hold", 32'(bus16.o_count), 32'h42);

        // Enable low freezes the prescaler one cycle into the period.
        en = 1'b0; step(10);
        chk("en_hold", 32'(bus10.o_count), 32'h42);
        en = 1'b1;
        wait_tick(nt);
        chk("resume_cycles", 32'(nt), 32'd2);
        step(1);
        chk("resume_step", 32'(bus10.o_count), 32'h43);

        // Display of a small value.
        ld = 1'b1; lv = 8'h05; step(1); ld = 1'b0; step(1);
        chk("seg_five", 32'(bus10.o_seg[6:0]), 32'(7'b0100100));
        chk("seg_hi_zero", 32'(bus10.o_seg[13:7]), 32'(hi_zero));

        // Asynchronous reset between clock edges.
        #1 rst = 1'b1;
        #1;
        chk("async_count", 32'(bus10.o_count), 32'h00);
        chk("async_seg", 32'(bus10.o_seg), 32'(seg_rst));
        chk("async_tick", 32'(bus10.o_tick), 32'h0);
        chk("async_count16", 32'(bus16.o_count), 32'h00);
        step(2);
        rst = 1'b0;
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/seven_seg_counter_n.md
Name: seven_seg_counter_n

Overview:
Parametrised successor to the fixed two-digit seven-segment counter used on the Go Board (25 MHz).
- Counts N_DIGITS digits in radix 10 or 16, stepping on an internal prescaler tick.
- Supports up/down direction, enable, synchronous clear and parallel load.
- Drives one 7-bit segment bus per digit.
- Sits between the board switch logic and the segment pins in the top level.

Parameters:
PERIOD, 25000000, i_Clk cycles per count step (>=2)
N_DIGITS, 2, number of display digits (1..8)
RADIX, 10, digit radix; only 10 or 16 legal (elaboration error otherwise)
SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (lit = 0)

Ports:
i_Clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_en  in  1  1 = prescaler runs and counter steps on tick
i_up  in  1  1 = count up, 0 = count down; sampled at each tick
i_clear  in  1  synchronous clear of count and prescaler
i_load  in  1  synchronous load of i_load_val
i_load_val  in  4*N_DIGITS  load value, digit k in bits [4k+3:4k]
o_count  out  4*N_DIGITS  current count, packed digits, digit 0 = least significant
o_seg  out  7*N_DIGITS  segments; digit k in [7k+6:7k], bit order A..G = [6]..[0]
o_tick  out  1  one-cycle pulse when the prescaler expires
o_wrap  out  1  one-cycle pulse on overflow or underflow

Behaviour:
- Reset (async assert, sync release):
  - Prescaler = 0, o_count = 0, o_tick = 0, o_wrap = 0.
  - o_seg shows "0" on every digit (see Optional Feature).
- Prescaler:
  - Increments while i_en = 1; holds while i_en = 0.
  - At PERIOD-1 it returns to 0 and asserts o_tick for exactly that cycle.
  - Tick period is exactly PERIOD cycles.
- Priority per cycle: i_clear > i_load > tick step.
  - i_clear: count = 0, prescaler = 0, no tick, no wrap.
  - i_load: count = i_load_val, with any digit >= RADIX clamped to RADIX-1. Prescaler is not reset; a coincident tick is discarded.
  - Tick, i_up = 1: digit 0 increments. A digit at RADIX-1 goes to 0 and carries into the next digit.
  - Tick, i_up = 0: digit 0 decrements. A digit at 0 goes to RADIX-1 and borrows from the next digit.
- Wrap:
  - Up from all digits at RADIX-1 gives all 0 and o_wrap = 1.
  - Down from all 0 gives all RADIX-1 and o_wrap = 1.
  - o_wrap is coincident with the count update, so it asserts in the cycle after the tick.
- Latency:
  - o_count updates the cycle after the tick, load or clear.
  - o_seg is registered and follows o_count one cycle later (2 cycles after tick).
- Decode (active-high polarity, ABCDEFG):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - SEG_ACTIVE_LOW = 1 inverts all bits.
- Direction and enable:
  - An i_up change between ticks affects only the next tick.
  - i_en falling mid-period freezes the prescaler value; counting resumes from that value.
- Reset mid-count: everything returns to reset values immediately, with no pending tick or wrap.

Optional Feature:
- Macro: SEVEN_SEG_BLANK_LEADING_EN.
- Defined:
  - Leading zero digits above the highest non-zero digit are blanked (all segments off, polarity-adjusted).
  - Digit 0 is never blanked; after reset only digit 0 shows "0".
  - Blanking is computed from the same registered count, so latency is unchanged.
- Undefined: every digit is always decoded, and zeros are shown.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16-entry segment pattern constant array;
  - SEG_BLANK = 7'b0000000;
  - SEG_W = 7, DIGIT_W = 4;
  - a function for polarity application.
- One sub-module, seven_seg_decode: combinational 4-bit digit plus blank flag to 7-bit pattern. It is instantiated N_DIGITS times via generate; the output register stays in the parent.

Test Plan:
1. PERIOD=4, N_DIGITS=2, RADIX=10, i_en=1, i_up=1 from reset: o_tick every 4th cycle; o_count 0x00 -> 0x01 ... 0x09 -> 0x10; o_seg digit 0 for "0" = 7'b0000001 (active-low).
2. Load 0x99, up, one tick: o_count = 0x00 and o_wrap high for exactly 1 cycle. Repeat with RADIX=16, load 0xFF: same result.
3. Count = 0x00, i_up=0, one tick: o_count = 0x99 (RADIX=10), o_wrap pulse. Then toggle i_up mid-period: next tick follows the new direction.
4. i_load_val = 0xC7 with RADIX=10: o_count = 0x97. Clear and load in the same cycle: o_count = 0x00. Load coincident with tick: count = load value, no extra step.
5. i_en low for 10 cycles mid-period: no tick, count holds; the first tick after re-enable arrives PERIOD minus the already-elapsed cycles later. rst asserted asynchronously mid-count: outputs reset without waiting for a clock edge.
6. With SEVEN_SEG_BLANK_LEADING_EN, N_DIGITS=3, count 0x005: digits 2 and 1 are all ones (blank, active-low), digit 0 shows "5" = 7'b0100100.
